// File: rtl/cr_sa_snap_reader_if.sv
// Readout beat channel from the SA snapshot reader toward the CSR/debug path.
interface cr_sa_snap_reader_if #(
  parameter int IDX_W = 4
) ();
  logic             rd_valid;
  logic             rd_ready;
  logic [31:0]      rd_data;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_hi;
  logic             rd_last;

  modport master (
    output rd_valid, rd_data, rd_idx, rd_hi, rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_valid, rd_data, rd_idx, rd_hi, rd_last,
    output rd_ready
  );
endinterface

// File: rtl/cr_sa_snap_reader.sv
// SA counter bank readout engine: strobes a snapshot (optionally with clear)
// and streams each 50-bit snapshot as a low word then a high word.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for dump_req; dump_clr latched on acceptance
// S_SNAP    | single cycle: sa_snap (and sa_clear if requested) high
// S_SEND_LO | offering bits [31:0] of counter idx
// S_SEND_HI | offering bits [49:32] of counter idx, zero-extended
// S_DONE    | single cycle done pulse, then back to idle
module cr_sa_snap_reader #(
  parameter int N_CTR = 16,
  parameter int IDX_W = (N_CTR > 1) ? $clog2(N_CTR) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_dump_req,
  input  logic                  i_dump_clr,
  input  logic [N_CTR*50-1:0]   i_sa_snapshot,
  output logic                  o_sa_snap,
  output logic                  o_sa_clear,
  output logic                  o_busy,
  output logic                  o_done,
  cr_sa_snap_reader_if.master   rd
);

  localparam logic [IDX_W-1:0] LP_IDX_LAST = IDX_W'(N_CTR - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SNAP    = 3'd1,
    S_SEND_LO = 3'd2,
    S_SEND_HI = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic             r_clr_q;
  logic             w_hs;
  logic [49:0]      w_word;

  // Handshake is derived from state so the output block never feeds back into itself.
  assign w_hs = ((r_state == S_SEND_LO) || (r_state == S_SEND_HI)) && rd.rd_ready;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Counter index and latched clear qualifier.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx   <= '0;
      r_clr_q <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && i_dump_req) r_clr_q <= i_dump_clr;
      if (r_state == S_SNAP) r_idx <= '0;
      else if ((r_state == S_SEND_HI) && w_hs && (r_idx != LP_IDX_LAST))
        r_idx <= r_idx + IDX_W'(1);
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (i_dump_req) w_state_nxt = S_SNAP;
      S_SNAP:    w_state_nxt = S_SEND_LO;
      S_SEND_LO: if (w_hs) w_state_nxt = S_SEND_HI;
      S_SEND_HI: if (w_hs) w_state_nxt = (r_idx == LP_IDX_LAST) ? S_DONE : S_SEND_LO;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Select the current counter's snapshot; the bank is frozen during a dump.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < N_CTR; k++) begin
      if (r_idx == IDX_W'(k)) w_word = i_sa_snapshot[k*50 +: 50];
    end
  end

  // Moore outputs.
  always_comb begin
    o_sa_snap   = 1'b0;
    o_sa_clear  = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    rd.rd_valid = 1'b0;
    rd.rd_data  = '0;
    rd.rd_idx   = '0;
    rd.rd_hi    = 1'b0;
    rd.rd_last  = 1'b0;
    unique case (r_state)
      S_IDLE: o_busy = 1'b0;
      S_SNAP: begin
        o_sa_snap  = 1'b1;
        o_sa_clear = r_clr_q;
      end
      S_SEND_LO: begin
        rd.rd_valid = 1'b1;
        rd.rd_data  = w_word[31:0];
        rd.rd_idx   = r_idx;
      end
      S_SEND_HI: begin
        rd.rd_valid = 1'b1;
        rd.rd_hi    = 1'b1;
        rd.rd_data  = {14'b0, w_word[49:32]};
        rd.rd_idx   = r_idx;
        rd.rd_last  = (r_idx == LP_IDX_LAST);
      end
      S_DONE:  o_done = 1'b1;
      default: o_busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cr_sa_snap_reader.sv
// Bench for cr_sa_snap_reader: a 4-counter instance checked every cycle
// against a beat-count model with an emulated counter bank, plus a
// single-counter instance checked with literal expectations.
module tb_cr_sa_snap_reader;

  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main DUT (N=4)
  logic             dump_req = 1'b0;
  logic             dump_clr = 1'b0;
  logic             rd_ready = 1'b1;
  logic [N*50-1:0]  snap_flat;
  logic             sa_snap, sa_clear, busy, done;
  cr_sa_snap_reader_if #(.IDX_W(IW)) rd_if ();
  assign rd_if.rd_ready = rd_ready;

  cr_sa_snap_reader #(.N_CTR(N), .IDX_W(IW)) dut (
    .i_clk(clk), .i_rst(rst), .i_dump_req(dump_req), .i_dump_clr(dump_clr),
    .i_sa_snapshot(snap_flat), .o_sa_snap(sa_snap), .o_sa_clear(sa_clear),
    .o_busy(busy), .o_done(done), .rd(rd_if)
  );

  // Single-counter DUT
  logic        d1_req = 1'b0;
  logic [49:0] d1_snapshot = 50'h2_ABCD_1234_5678;
  logic        d1_sa_snap, d1_sa_clear, d1_busy, d1_done;
  cr_sa_snap_reader_if #(.IDX_W(1)) rd_if1 ();
  assign rd_if1.rd_ready = 1'b1;

  cr_sa_snap_reader #(.N_CTR(1), .IDX_W(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_dump_req(d1_req), .i_dump_clr(1'b0),
    .i_sa_snapshot(d1_snapshot), .o_sa_snap(d1_sa_snap), .o_sa_clear(d1_sa_clear),
    .o_busy(d1_busy), .o_done(d1_done), .rd(rd_if1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Stimulus knobs
  logic [N-1:0] ev = '0;
  logic         ev_en = 1'b0;
  logic         ev_all = 1'b0;
  logic         ready_rand = 1'b0;
  logic         ld_en = 1'b0;
  logic [49:0]  ld_val [N];
  logic         chk_en = 1'b0;

  // Emulated counter bank, driven by the DUT strobes
  logic [49:0] cnt_env  [N] = '{default: '0};
  logic [49:0] snap_env [N] = '{default: '0};

  always_comb begin
    snap_flat = '0;
    for (int k = 0; k < N; k++) snap_flat[k*50 +: 50] = snap_env[k];
  end

  // Reference model: dump progress as a beat number, own copy of the counters
  logic        m_snap = 1'b0;
  logic        m_clr  = 1'b0;
  logic        m_done = 1'b0;
  int          m_beat = -1;
  logic [49:0] m_cnt [N] = '{default: '0};
  logic [49:0] m_img [N] = '{default: '0};

  // Advance the counter bank and the model on every clock edge.
  always @(posedge clk) begin
    logic snap_now, clr_now;
    for (int k = 0; k < N; k++) begin
      if (sa_snap) snap_env[k] <= cnt_env[k];
      if (ld_en)         cnt_env[k] <= ld_val[k];
      else if (sa_clear) cnt_env[k] <= '0;
      else               cnt_env[k] <= cnt_env[k] + 50'(ev[k]);
    end
    snap_now = m_snap;
    clr_now  = m_snap && m_clr;
    for (int k = 0; k < N; k++) begin
      if (snap_now) m_img[k] = m_cnt[k];
      if (ld_en)        m_cnt[k] = ld_val[k];
      else if (clr_now) m_cnt[k] = '0;
      else              m_cnt[k] = m_cnt[k] + 50'(ev[k]);
    end
    if (rst) begin
      m_snap = 1'b0; m_clr = 1'b0; m_done = 1'b0; m_beat = -1;
    end else if (m_snap) begin
      m_snap = 1'b0; m_beat = 0;
    end else if (m_beat >= 0) begin
      if (rd_ready) begin
        if (m_beat == 2*N-1) begin m_beat = -1; m_done = 1'b1; end
        else m_beat++;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (dump_req) begin
      m_snap = 1'b1; m_clr = dump_clr;
    end
  end

  // Captured beats and strobe statistics
  logic [31:0] cap_d [$];
  logic        cap_last [$];
  int          cap_idx [$];
  logic        cap_hi [$];
  int n_snap = 0, n_clr = 0, n_snapclr = 0, n_done = 0;
  logic [31:0] c1_d [$];
  logic        c1_last [$];
  int          d1_badidx = 0, d1_ndone = 0;

  // Per-cycle comparison against the model, plus beat capture.
  always @(negedge clk) begin
    logic        e_valid, e_hi, e_last;
    int          e_idx;
    logic [49:0] w;
    logic [31:0] e_data;
    if (chk_en) begin
      e_valid = (m_beat >= 0);
      e_idx   = e_valid ? m_beat / 2 : 0;
      e_hi    = e_valid ? (m_beat % 2 == 1) : 1'b0;
      e_last  = (m_beat == 2*N-1);
      w       = m_img[e_idx];
      e_data  = e_hi ? {14'b0, w[49:32]} : w[31:0];
      chk("sa_snap",  sa_snap,  m_snap);
      chk("sa_clear", sa_clear, m_snap && m_clr);
      chk("busy",     busy,     m_snap || e_valid || m_done);
      chk("done",     done,     m_done);
      chk("rd_valid", rd_if.rd_valid, e_valid);
      chk("rd_last",  rd_if.rd_last,  e_last);
      chk("rd_idx",   rd_if.rd_idx,   e_idx);
      chk("rd_hi",    rd_if.rd_hi,    e_hi);
      if (e_valid) chk("rd_data", rd_if.rd_data, e_data);

      if (rd_if.rd_valid && rd_ready) begin
        cap_d.push_back(rd_if.rd_data);
        cap_last.push_back(rd_if.rd_last);
        cap_idx.push_back(int'(rd_if.rd_idx));
        cap_hi.push_back(rd_if.rd_hi);
      end
      if (sa_snap) n_snap++;
      if (sa_clear) n_clr++;
      if (sa_snap && sa_clear) n_snapclr++;
      if (done) n_done++;

      if (rd_if1.rd_valid) begin
        c1_d.push_back(rd_if1.rd_data);
        c1_last.push_back(rd_if1.rd_last);
        if (rd_if1.rd_idx != 1'b0) d1_badidx++;
      end
      if (d1_done) d1_ndone++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    for (int k = 0; k < N; k++)
      ev[k] = ev_all ? 1'b1 : (ev_en ? 1'($urandom_range(0, 1)) : 1'b0);
    rd_ready = ready_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
  endtask

  task automatic clear_stats();
    cap_d.delete(); cap_last.delete(); cap_idx.delete(); cap_hi.delete();
    n_snap = 0; n_clr = 0; n_snapclr = 0; n_done = 0;
  endtask

  // Wait for idle, then hold dump_req for exactly one accepting edge.
  task automatic start_dump(input logic clr);
    for (int i = 0; i < 8 && busy; i++) tick();
    dump_req = 1'b1;
    dump_clr = clr;
    tick();
    dump_req = 1'b0;
  endtask

  task automatic wait_done(output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      n++;
      seen = done;
    end
    chk("done_seen", seen, 1'b1);
  endtask

  task automatic load_cnt(input logic [49:0] v0, input logic [49:0] v1,
                          input logic [49:0] v2, input logic [49:0] v3);
    ld_val[0] = v0; ld_val[1] = v1; ld_val[2] = v2; ld_val[3] = v3;
    ld_en = 1'b1;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_snap"},  sa_snap, 1'b0);
    chk({tag, "_clear"}, sa_clear, 1'b0);
    chk({tag, "_busy"},  busy, 1'b0);
    chk({tag, "_done"},  done, 1'b0);
    chk({tag, "_valid"}, rd_if.rd_valid, 1'b0);
    chk({tag, "_data"},  rd_if.rd_data, 32'h0);
    chk({tag, "_idx"},   rd_if.rd_idx, 2'd0);
    chk({tag, "_hi"},    rd_if.rd_hi, 1'b0);
    chk({tag, "_last"},  rd_if.rd_last, 1'b0);
  endtask

  logic [31:0] basic_exp [8] = '{32'hFFFF_FFFF, 32'h0003_FFFF, 32'h0000_0001, 32'h0,
                                 32'h0, 32'h0, 32'h0000_0001, 32'h0002_0000};

  initial begin
    int nc;
    ld_val = '{default: '0};

    // Reset
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Basic dump
    load_cnt(50'h3_FFFF_FFFF_FFFF, 50'h1, 50'h0, 50'h2_0000_0000_0001);
    clear_stats();
    start_dump(1'b0);
    wait_done(nc);
    chk("basic_done_latency", nc, 2*N+1);
    chk("basic_beats", cap_d.size(), 8);
    for (int i = 0; i < 8 && i < cap_d.size(); i++) begin
      chk($sformatf("basic_beat%0d", i), cap_d[i], basic_exp[i]);
      chk($sformatf("basic_last%0d", i), cap_last[i], (i == 7));
    end
    chk("basic_no_clear", n_clr, 0);
    chk("basic_one_snap", n_snap, 1);
    chk("model_img3", m_img[3], 50'h2_0000_0000_0001);

    // Clear dump: events hit in the SNAP cycle and are lost
    tick();
    load_cnt(50'd100, 50'd100, 50'd100, 50'd100);
    clear_stats();
    ev_all = 1'b1;
    start_dump(1'b1);
    ev_all = 1'b0;
    wait_done(nc);
    chk("clr_snap_cycles", n_snap, 1);
    chk("clr_clear_cycles", n_clr, 1);
    chk("clr_same_cycle", n_snapclr, 1);
    chk("clr_beats", cap_d.size(), 8);
    for (int i = 0; i < cap_d.size(); i++)
      chk($sformatf("clr_beat%0d", i), cap_d[i], (i % 2 == 0) ? 32'd100 : 32'd0);
    chk("model_img0_100", m_img[0], 50'd100);
    clear_stats();
    start_dump(1'b0);
    wait_done(nc);
    chk("reread_beats", cap_d.size(), 8);
    for (int i = 0; i < cap_d.size(); i++)
      chk($sformatf("reread_beat%0d", i), cap_d[i], 32'd0);

    // Back-pressure with running counters
    ev_en = 1'b1;
    ready_rand = 1'b1;
    repeat (3) begin
      repeat ($urandom_range(2, 6)) tick();
      clear_stats();
      start_dump(1'($urandom_range(0, 1)));
      wait_done(nc);
      chk("bp_handshakes", cap_d.size(), 2*N);
      for (int i = 0; i < cap_idx.size(); i++) begin
        chk($sformatf("bp_idx%0d", i), cap_idx[i], i / 2);
        chk($sformatf("bp_hi%0d", i), cap_hi[i], (i % 2 == 1));
      end
    end
    ready_rand = 1'b0;
    tick();

    // Request while busy: pulse during SEND_LO of counter 2
    clear_stats();
    start_dump(1'b0);
    repeat (5) tick();
    chk("rwb_pos_idx", rd_if.rd_idx, 2'd2);
    chk("rwb_pos_hi", rd_if.rd_hi, 1'b0);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    wait_done(nc);
    chk("rwb_one_snap", n_snap, 1);
    chk("rwb_beats", cap_d.size(), 8);
    tick();
    chk("rwb_idle_after_done", busy, 1'b0);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    chk("rwb_accept_after_done", sa_snap, 1'b1);
    wait_done(nc);
    tick();

    // Reset during SEND_HI of counter 1
    ev_en = 1'b0;
    start_dump(1'b0);
    repeat (4) tick();
    chk("rst_pos_idx", rd_if.rd_idx, 2'd1);
    chk("rst_pos_hi", rd_if.rd_hi, 1'b1);
    clear_stats();
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (3) tick();
    chk("midrst_no_done", n_done, 0);
    clear_stats();
    start_dump(1'b0);
    wait_done(nc);
    chk("fresh_beats", cap_d.size(), 8);
    if (cap_idx.size() > 0) begin
      chk("fresh_first_idx", cap_idx[0], 0);
      chk("fresh_first_hi", cap_hi[0], 1'b0);
    end

    // Single-counter instance
    c1_d.delete(); c1_last.delete(); d1_badidx = 0; d1_ndone = 0;
    d1_req = 1'b1;
    tick();
    d1_req = 1'b0;
    repeat (8) tick();
    chk("n1_beats", c1_d.size(), 2);
    if (c1_d.size() == 2) begin
      chk("n1_lo", c1_d[0], 32'h1234_5678);
      chk("n1_hi", c1_d[1], 32'h0002_ABCD);
      chk("n1_last0", c1_last[0], 1'b0);
      chk("n1_last1", c1_last[1], 1'b1);
    end
    chk("n1_idx_zero", d1_badidx, 0);
    chk("n1_done_once", d1_ndone, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
